// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: opcodes, FSM states
// and opcode-class helpers.
package mem_stage_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SHL  = 4'h5,
    OP_SHR  = 4'h6,
    OP_LI   = 4'h7,
    OP_LW   = 4'h8,
    OP_SW   = 4'h9,
    OP_BEQ  = 4'hA,
    OP_JMP  = 4'hB,
    OP_CALL = 4'hC,
    OP_RET  = 4'hD,
    OP_NOP  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ERROR  = 2'd2
  } state_e;

  function automatic logic is_mem_op(input logic [3:0] op);
    return op inside {OP_LW, OP_SW, OP_CALL, OP_RET};
  endfunction

  function automatic logic is_read_op(input logic [3:0] op);
    return op inside {OP_LW, OP_RET};
  endfunction

  function automatic logic is_sp_op(input logic [3:0] op);
    return op inside {OP_CALL, OP_RET};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the memory stage
// and the data memory.
interface mem_stage_if #(
  parameter int W = 16
);
  logic         req;
  logic         we;
  logic [W-1:0] addr;
  logic [W-1:0] wdata;
  logic [W-1:0] rdata;
  logic         ack;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/mem_timeout_ctr.sv
// Clear/enable counter; tc_o flags the increment that
// would bring the count to MAX.
module mem_timeout_ctr #(
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = en_i && (cnt_q == W'(MAX - 1));

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues LW/SW/CALL/RET
// over req/ack, stalls upstream, registers the WB bundle.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [15:0]       ex_instr,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_rt,
  output logic              stall,
  mem_stage_if.master       dm,
  output logic              wb_valid,
  output logic [15:0]       wb_instr,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] wb_sp,
  output logic              mem_err
);

  state_e            state_q, state_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] sp_q, sp_d;
  logic [15:0]       instr_q, instr_d;
  logic              wbv_q, wbv_d;
  logic [15:0]       wbi_q, wbi_d;
  logic [DATA_W-1:0] wbd_q, wbd_d;
  logic [DATA_W-1:0] wbs_q, wbs_d;
  logic              err_q, err_d;

  logic [3:0] op;
  logic       idle_take;
  logic       take_mem;
  logic       take_alu;
  logic       to_en;
  logic       to_tc;

  assign op = ex_instr[15:12];

  // done_q: the held op was just retired, so don't re-issue it
  assign idle_take = (state_q == S_IDLE) && ex_valid && !done_q;
  assign take_mem  = idle_take && is_mem_op(op);
  assign take_alu  = idle_take && !is_mem_op(op);

  assign to_en = (state_q == S_ACCESS) && !dm.ack;

  mem_timeout_ctr #(
    .MAX(TIMEOUT)
  ) u_to (
    .clk  (clk),
    .rst  (rst),
    .clr_i(!to_en),
    .en_i (to_en),
    .tc_o (to_tc)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sp_d    = sp_q;
    instr_d = instr_q;
    wbv_d   = 1'b0;
    wbi_d   = wbi_q;
    wbd_d   = wbd_q;
    wbs_d   = wbs_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          take_alu: begin
            wbv_d = 1'b1;
            wbi_d = ex_instr;
            wbd_d = ex_result;
            wbs_d = '0;
          end
          take_mem: begin
            state_d = S_ACCESS;
            we_d    = !is_read_op(op);
            addr_d  = (op == OP_RET)
                    ? ex_result - DATA_W'(1)
                    : ex_result;
            wdata_d = ex_rt;
            instr_d = ex_instr;
            sp_d    = is_sp_op(op) ? ex_result : '0;
          end
          default: ;
        endcase
      end
      S_ACCESS: begin
        if (dm.ack) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          wbv_d   = 1'b1;
          wbi_d   = instr_q;
          wbd_d   = we_q ? wdata_q : dm.rdata;
          wbs_d   = sp_q;
        end else if (to_tc) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end
      end
      S_ERROR: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sp_q    <= '0;
      instr_q <= '0;
      wbv_q   <= 1'b0;
      wbi_q   <= '0;
      wbd_q   <= '0;
      wbs_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sp_q    <= sp_d;
      instr_q <= instr_d;
      wbv_q   <= wbv_d;
      wbi_q   <= wbi_d;
      wbd_q   <= wbd_d;
      wbs_q   <= wbs_d;
      err_q   <= err_d;
    end
  end

  assign stall    = (state_q != S_IDLE) || take_mem;
  assign dm.req   = (state_q == S_ACCESS);
  assign dm.we    = we_q;
  assign dm.addr  = addr_q;
  assign dm.wdata = wdata_q;
  assign wb_valid = wbv_q;
  assign wb_instr = wbi_q;
  assign wb_data  = wbd_q;
  assign wb_sp    = wbs_q;
  assign mem_err  = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table,
// directed corner sequences and a random scoreboard.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [15:0] ex_instr;
  logic [15:0] ex_result;
  logic [15:0] ex_rt;
  logic        stall;
  logic        wb_valid;
  logic [15:0] wb_instr;
  logic [15:0] wb_data;
  logic [15:0] wb_sp;
  logic        mem_err;

  mem_stage_if #(.W(16)) dm();

  mem_stage #(
    .DATA_W (16),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ex_valid (ex_valid),
    .ex_instr (ex_instr),
    .ex_result(ex_result),
    .ex_rt    (ex_rt),
    .stall    (stall),
    .dm       (dm),
    .wb_valid (wb_valid),
    .wb_instr (wb_instr),
    .wb_data  (wb_data),
    .wb_sp    (wb_sp),
    .mem_err  (mem_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  bit [15:0] mem    [65536];
  bit [15:0] refmem [65536];

  typedef struct packed {
    int          nreq;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          held_bad;
    bit          stall_bad;
    int          wb_cnt;
    logic [15:0] wbi;
    logic [15:0] wbd;
    logic [15:0] wbs;
    int          ack_cyc;
    int          wb_cyc;
    int          slo_cyc;
    bit          tmo;
  } obs_t;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] res;
    logic [15:0] rt;
    int          dly;
    bit          is_mem;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] wbd;
    logic [15:0] wbs;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one instruction, act as memory, watch WB.
  task automatic run_one(input logic [15:0] ins,
                         input logic [15:0] res,
                         input logic [15:0] rt,
                         input int dly,
                         output obs_t o);
    int cyc;
    int tail;
    bit leaving;
    o = '0;
    o.ack_cyc = -1;
    o.wb_cyc  = -1;
    o.slo_cyc = -1;
    ex_valid  = 1'b1;
    ex_instr  = ins;
    ex_result = res;
    ex_rt     = rt;
    cyc = 0;
    tail = 0;
    leaving = 1'b0;
    while (tail < 3 && cyc < 40) begin
      #1;
      if (dm.req) begin
        if (!stall) o.stall_bad = 1'b1;
        if (o.nreq > 0 && (dm.we !== o.we ||
            dm.addr !== o.addr ||
            dm.wdata !== o.wdata))
          o.held_bad = 1'b1;
        o.we    = dm.we;
        o.addr  = dm.addr;
        o.wdata = dm.wdata;
        if (o.nreq == dly) begin
          dm.ack = 1'b1;
          o.ack_cyc = cyc;
          if (dm.we) mem[dm.addr] = dm.wdata;
          else       dm.rdata = mem[dm.addr];
        end
        o.nreq++;
      end
      if (wb_valid) begin
        if (o.wb_cnt == 0) begin
          o.wb_cyc = cyc;
          o.wbi = wb_instr;
          o.wbd = wb_data;
          o.wbs = wb_sp;
        end
        o.wb_cnt++;
      end
      if (leaving) tail++;
      else if (!stall) begin
        leaving = 1'b1;
        o.slo_cyc = cyc;
      end
      tick();
      dm.ack = 1'b0;
      if (leaving) ex_valid = 1'b0;
      cyc++;
    end
    if (cyc >= 40) o.tmo = 1'b1;
    ex_valid = 1'b0;
  endtask

  task automatic check_obs(input string nm,
                           input vec_t v,
                           input obs_t o);
    chk({nm, "_tmo"}, o.tmo, 0);
    chk({nm, "_wbcnt"}, o.wb_cnt, 1);
    chk({nm, "_wbi"}, o.wbi, v.ins);
    chk({nm, "_wbd"}, o.wbd, v.wbd);
    chk({nm, "_wbs"}, o.wbs, v.wbs);
    if (v.is_mem) begin
      chk({nm, "_nreq"}, o.nreq, v.dly + 1);
      chk({nm, "_we"}, o.we, v.we);
      chk({nm, "_addr"}, o.addr, v.addr);
      chk({nm, "_wdata"}, o.wdata, v.wdata);
      chk({nm, "_held"}, o.held_bad, 0);
      chk({nm, "_stall"}, o.stall_bad, 0);
      chk({nm, "_wblat"}, o.wb_cyc, o.ack_cyc + 1);
      chk({nm, "_slo"}, o.slo_cyc, o.ack_cyc + 1);
    end else begin
      chk({nm, "_nreq"}, o.nreq, 0);
      chk({nm, "_wblat"}, o.wb_cyc, 1);
      chk({nm, "_slo"}, o.slo_cyc, 0);
    end
  endtask

  // Reference: instruction semantics at transaction level.
  function automatic vec_t model(input logic [15:0] ins,
                                 input logic [15:0] res,
                                 input logic [15:0] rt,
                                 input int dly);
    vec_t v;
    v.ins = ins; v.res = res; v.rt = rt; v.dly = dly;
    v.is_mem = 1'b1;
    v.wdata = rt;
    v.wbs = 16'h0;
    case (ins[15:12])
      OP_LW: begin
        v.we = 0; v.addr = res; v.wbd = refmem[res];
      end
      OP_SW: begin
        v.we = 1; v.addr = res; v.wbd = rt;
        refmem[res] = rt;
      end
      OP_CALL: begin
        v.we = 1; v.addr = res; v.wbd = rt;
        v.wbs = res; refmem[res] = rt;
      end
      OP_RET: begin
        v.we = 0; v.addr = res - 16'd1;
        v.wbd = refmem[v.addr]; v.wbs = res;
      end
      default: begin
        v.is_mem = 0; v.we = 0; v.addr = 0;
        v.wbd = res;
      end
    endcase
    return v;
  endfunction

  vec_t tbl[9];

  initial begin
    obs_t o;
    int n;
    int seen;
    logic [15:0] last;

    tbl[0] = '{16'h0123, 16'h1234, 16'h5555, 0, 0,
               0, 16'h0, 16'h0, 16'h1234, 16'h0};
    tbl[1] = '{16'h9210, 16'h0040, 16'hBEEF, 2, 1,
               1, 16'h0040, 16'hBEEF, 16'hBEEF, 16'h0};
    tbl[2] = '{16'h8300, 16'h0010, 16'h0000, 0, 1,
               0, 16'h0010, 16'h0000, 16'hCAFE, 16'h0};
    tbl[3] = '{16'hC000, 16'h00FE, 16'h0123, 1, 1,
               1, 16'h00FE, 16'h0123, 16'h0123, 16'h00FE};
    tbl[4] = '{16'hD500, 16'h00FF, 16'h0000, 0, 1,
               0, 16'h00FE, 16'h0000, 16'h0123, 16'h00FF};
    tbl[5] = '{16'h8400, 16'h0040, 16'h7777, 3, 1,
               0, 16'h0040, 16'h7777, 16'hBEEF, 16'h0};
    tbl[6] = '{16'hD000, 16'h0000, 16'h0000, 1, 1,
               0, 16'hFFFF, 16'h0000, 16'hA5A5, 16'h0000};
    tbl[7] = '{16'h7ABC, 16'hFFFF, 16'h1111, 0, 0,
               0, 16'h0, 16'h0, 16'hFFFF, 16'h0};
    tbl[8] = '{16'h9000, 16'h0200, 16'h0F0F, TO - 1, 1,
               1, 16'h0200, 16'h0F0F, 16'h0F0F, 16'h0};

    mem[16'h0010] = 16'hCAFE;
    mem[16'hFFFF] = 16'hA5A5;

    rst = 1'b1;
    ex_valid = 1'b0;
    ex_instr = '0;
    ex_result = '0;
    ex_rt = '0;
    dm.ack = 1'b0;
    dm.rdata = '0;
    tick();
    tick();
    #1;
    chk("rst_wbv", wb_valid, 0);
    chk("rst_wbd", wb_data, 0);
    chk("rst_wbs", wb_sp, 0);
    chk("rst_wbi", wb_instr, 0);
    chk("rst_req", dm.req, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_one(tbl[i].ins, tbl[i].res, tbl[i].rt,
              tbl[i].dly, o);
      check_obs($sformatf("vec%0d", i), tbl[i], o);
    end

    // Spurious ack in IDLE
    dm.ack = 1'b1;
    dm.rdata = 16'hFFFF;
    #1;
    chk("spur_req", dm.req, 0);
    tick();
    dm.ack = 1'b0;
    #1;
    chk("spur_wbv", wb_valid, 0);
    chk("spur_err", mem_err, 0);
    tick();

    // Back-to-back ALU ops, one per cycle
    last = 16'h0;
    for (int i = 0; i < 5; i++) begin
      ex_valid = 1'b1;
      ex_instr = 16'h1000 | 16'(i);
      ex_result = 16'h1111 * 16'(i + 1);
      #1;
      chk($sformatf("b2b%0d_stall", i), stall, 0);
      if (i > 0) begin
        chk($sformatf("b2b%0d_wbv", i), wb_valid, 1);
        chk($sformatf("b2b%0d_wbd", i), wb_data, last);
      end
      last = ex_result;
      tick();
    end
    ex_valid = 1'b0;
    #1;
    chk("b2b_lastv", wb_valid, 1);
    chk("b2b_lastd", wb_data, last);
    tick();
    #1;
    chk("hold_wbv", wb_valid, 0);
    chk("hold_wbd", wb_data, last);
    tick();

    // Random traffic against the reference model
    refmem = mem;
    for (int i = 0; i < 60; i++) begin
      vec_t v;
      logic [15:0] ins;
      logic [15:0] res;
      ins = 16'($urandom);
      res = 16'($urandom_range(0, 31));
      if (i % 7 == 0) res = 16'($urandom);
      v = model(ins, res, 16'($urandom),
                int'($urandom_range(0, TO - 1)));
      run_one(v.ins, v.res, v.rt, v.dly, o);
      check_obs($sformatf("rnd%0d", i), v, o);
    end

    // Timeout: LW that never gets an ack
    ex_valid = 1'b1;
    ex_instr = 16'h8000;
    ex_result = 16'h0100;
    n = 0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (dm.req) n++;
      if (wb_valid) seen++;
      if (n > 0 && !dm.req) break;
      tick();
    end
    chk("to_nreq", n, TO);
    chk("to_req", dm.req, 0);
    chk("to_err", mem_err, 1);
    chk("to_stall", stall, 1);
    ex_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      if (wb_valid) seen++;
    end
    chk("to_wb", seen, 0);
    chk("to_err_sticky", mem_err, 1);
    chk("to_stall_sticky", stall, 1);
    rst = 1'b1;
    #1;
    chk("to_rst_err", mem_err, 0);
    chk("to_rst_stall", stall, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Reset on the 2nd ACCESS cycle of a SW
    ex_valid = 1'b1;
    ex_instr = 16'h9000;
    ex_result = 16'h0300;
    ex_rt = 16'h1357;
    tick();
    #1;
    chk("mr_req1", dm.req, 1);
    tick();
    #1;
    chk("mr_req2", dm.req, 1);
    #2;
    rst = 1'b1;
    ex_valid = 1'b0;
    #1;
    chk("mr_req_async", dm.req, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (wb_valid || dm.req || stall) seen++;
      tick();
    end
    chk("mr_quiet", seen, 0);
    chk("mr_err", mem_err, 0);
    chk("mr_nowrite", mem[16'h0300], 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
